// File: rtl/wb_mem_readback_pkg.sv
// Shared types and Wishbone constants for the memory readback master.
package wb_readback_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      PUSH = 2'd2,
      DONE = 2'd3
   } state_e;

   localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
   localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;
   localparam logic [3:0] SEL_ALL        = 4'hf;

endpackage

// File: rtl/wb_mem_readback_if.sv
// Wishbone B3 classic bus bundle; master drives the request, slave the response.
interface wb_mem_readback_if #(
   parameter int AW = 32
) ();

   logic [AW-1:0] adr;
   logic          cyc;
   logic          stb;
   logic          we;
   logic [3:0]    sel;
   logic [2:0]    cti;
   logic [1:0]    bte;
   logic [31:0]   dat;
   logic          ack;
   logic          err;

   modport master (output adr, cyc, stb, we, sel, cti, bte, input dat, ack, err);
   modport slave  (input adr, cyc, stb, we, sel, cti, bte, output dat, ack, err);

endinterface

// File: rtl/wb_mem_readback.sv
// Wishbone classic read master: reads num_words words from base, streams each
// word out on a valid/ready port and accumulates an additive checksum.
module wb_mem_readback
   import wb_readback_pkg::*;
#(
   parameter int AW      = 32,
   parameter int CNTW    = 16,
   parameter int TIMEOUT = 255
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_n_i,
   input  logic            start_i,
   input  logic [AW-1:0]   base_adr_i,
   input  logic [CNTW-1:0] num_words_i,
   output logic            busy_o,
   output logic            done_o,
   output logic            err_o,
   output logic [31:0]     checksum_o,
   output logic [31:0]     rd_data_o,
   output logic [AW-1:0]   rd_adr_o,
   output logic            rd_valid_o,
   input  logic            rd_ready_i,
   wb_mem_readback_if.master wbm
);

   localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   state_e          state_q, state_d;
   logic [AW-1:0]   adr_q, adr_d;
   logic [CNTW-1:0] rem_q, rem_d;
   logic [31:0]     sum_q, sum_d;
   logic [31:0]     data_q, data_d;
   logic [AW-1:0]   radr_q, radr_d;
   logic [TW-1:0]   tmr_q, tmr_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            err_q, err_d;

   logic start_ok, timed_out, in_req;
   logic unused_base_lsb;

   assign unused_base_lsb = ^base_adr_i[1:0];
   assign start_ok  = (state_q == IDLE) && start_i;
   assign in_req    = (state_q == REQ);
   assign timed_out = (TIMEOUT != 0) && (tmr_q == TW'(TIMEOUT));

   // State register; reset drops the bus cycle immediately via the state decode
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) state_q <= IDLE;
      else             state_q <= state_d;
   end

   // Next-state: err beats ack, and a word that arrives on the timeout cycle is kept
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start_i) state_d = (num_words_i == '0) ? DONE : REQ;
         REQ: begin
            if (wbm.err)        state_d = DONE;
            else if (wbm.ack)   state_d = PUSH;
            else if (timed_out) state_d = DONE;
         end
         PUSH: if (rd_ready_i) state_d = (rem_q != '0) ? REQ : DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Bus and stream strobes decoded from state
   always_comb begin
      wbm.cyc    = in_req;
      wbm.stb    = in_req;
      rd_valid_o = (state_q == PUSH);
   end

   // Datapath next-state: address/count latch, capture on ack, checksum, wait timer
   always_comb begin
      adr_d  = adr_q;
      rem_d  = rem_q;
      sum_d  = sum_q;
      data_d = data_q;
      radr_d = radr_q;
      busy_d = busy_q;
      err_d  = err_q;
      done_d = (state_q == DONE);
      tmr_d  = in_req ? tmr_q + TW'(1) : '0;
      if (start_ok) begin
         adr_d  = {base_adr_i[AW-1:2], 2'b00};
         rem_d  = num_words_i;
         sum_d  = '0;
         err_d  = 1'b0;
         busy_d = 1'b1;
      end
      if (in_req) begin
         if (wbm.err) begin
            err_d = 1'b1;
         end else if (wbm.ack) begin
            data_d = wbm.dat;
            radr_d = adr_q;
            sum_d  = sum_q + wbm.dat;
            rem_d  = rem_q - CNTW'(1);
            adr_d  = adr_q + AW'(4);
         end else if (timed_out) begin
            err_d = 1'b1;
         end
      end
      // busy falls together with the registered done pulse
      if (state_q == DONE) busy_d = 1'b0;
   end

   // Datapath registers
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         adr_q  <= '0;
         rem_q  <= '0;
         sum_q  <= '0;
         data_q <= '0;
         radr_q <= '0;
         tmr_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         adr_q  <= adr_d;
         rem_q  <= rem_d;
         sum_q  <= sum_d;
         data_q <= data_d;
         radr_q <= radr_d;
         tmr_q  <= tmr_d;
         busy_q <= busy_d;
         done_q <= done_d;
         err_q  <= err_d;
      end
   end

   assign wbm.adr    = adr_q;
   assign wbm.we     = 1'b0;
   assign wbm.sel    = SEL_ALL;
   assign wbm.cti    = WB_CTI_CLASSIC;
   assign wbm.bte    = WB_BTE_LINEAR;
   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign err_o      = err_q;
   assign checksum_o = sum_q;
   assign rd_data_o  = data_q;
   assign rd_adr_o   = radr_q;

endmodule

// File: tb/tb_wb_mem_readback.sv
// Scoreboard bench for wb_mem_readback: a memory slave model, expected beats and
// done results queued by the stimulus, monitors compare on every handshake/done.
module tb_wb_mem_readback;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] base = '0;
   logic [15:0] nw = '0;
   logic        ready = 1'b1;
   logic        busy, done, err, rvalid;
   logic [31:0] csum, rdata, radr;

   wb_mem_readback_if #(.AW(32)) bus ();

   wb_mem_readback #(.AW(32), .CNTW(16), .TIMEOUT(8)) dut (
      .wb_clk_i   (clk),
      .wb_rst_n_i (rst_n),
      .start_i    (start),
      .base_adr_i (base),
      .num_words_i(nw),
      .busy_o     (busy),
      .done_o     (done),
      .err_o      (err),
      .checksum_o (csum),
      .rd_data_o  (rdata),
      .rd_adr_o   (radr),
      .rd_valid_o (rvalid),
      .rd_ready_i (ready),
      .wbm        (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int beats = 0;
   int dones = 0;
   int cyc_cnt = 0;

   typedef struct { logic [31:0] d; logic [31:0] a; } beat_t;
   typedef struct { logic [31:0] s; logic e; } dres_t;
   beat_t beat_q[$];
   dres_t done_q[$];

   logic [31:0] mem [16];
   logic        noack = 1'b0;
   logic        err_en = 1'b0;
   logic [31:0] err_adr = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic exp_beat(input logic [31:0] d, input logic [31:0] a);
      beat_t b;
      b.d = d; b.a = a;
      beat_q.push_back(b);
   endtask

   task automatic exp_done(input logic [31:0] s, input logic e);
      dres_t r;
      r.s = s; r.e = e;
      done_q.push_back(r);
   endtask

   // Classic slave: one-cycle ack (or err on a chosen address), optional no-response
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.ack <= 1'b0;
         bus.err <= 1'b0;
         bus.dat <= '0;
      end else begin
         bus.ack <= 1'b0;
         bus.err <= 1'b0;
         if (bus.cyc && bus.stb && !bus.ack && !bus.err && !noack) begin
            if (err_en && bus.adr == err_adr) bus.err <= 1'b1;
            else begin
               bus.ack <= 1'b1;
               bus.dat <= mem[bus.adr[5:2]];
            end
         end
      end
   end

   // Monitor: stream beats and done results against the scoreboard
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.cyc) cyc_cnt++;
         if (rvalid && ready) begin
            beats++;
            if (beat_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_beat: got data %0h adr %0h, none expected", rdata, radr);
            end else begin
               beat_t b;
               b = beat_q.pop_front();
               check("beat_data", rdata, b.d);
               check("beat_adr", radr, b.a);
            end
         end
         if (done) begin
            dones++;
            if (done_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_done: got done, none expected");
            end else begin
               dres_t r;
               r = done_q.pop_front();
               check("done_checksum", csum, r.s);
               check("done_err", err, r.e);
            end
         end
      end
   end

   task automatic do_start(input logic [31:0] b, input logic [15:0] n);
      @(posedge clk); #1;
      start = 1'b1; base = b; nw = n;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (done) return;
      end
      checks++; errors++;
      $display("FAIL done_timeout: got no done within %0d cycles, required done", budget);
   endtask

   task automatic wait_valid(input int budget);
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (rvalid) return;
      end
      checks++; errors++;
      $display("FAIL valid_timeout: got no rd_valid within %0d cycles", budget);
   endtask

   initial begin
      int d0, b0, c0;
      bit seen;
      for (int i = 0; i < 16; i++) mem[i] = 32'(i + 1);
      mem[15] = 32'h0000_0100;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy_done_err", {busy, done, err, rvalid}, 4'b0000);
      check("rst_checksum", csum, 0);
      check("rst_rd_data", rdata, 0);
      check("rst_rd_adr", radr, 0);
      check("rst_cyc_stb", {bus.cyc, bus.stb}, 2'b00);
      check("tied_we_sel_cti_bte", {bus.we, bus.sel, bus.cti, bus.bte}, {1'b0, 4'hf, 3'b000, 2'b00});
      @(posedge clk); #1;
      rst_n = 1'b1;

      // T1: four words, ready always high
      exp_beat(1, 32'h0); exp_beat(2, 32'h4); exp_beat(3, 32'h8); exp_beat(4, 32'hC);
      exp_done(32'hA, 1'b0);
      d0 = dones; b0 = beats;
      do_start(32'h0, 16'd4);
      wait_done(100);
      repeat (3) @(negedge clk);
      check("t1_done_pulses", dones - d0, 1);
      check("t1_beats", beats - b0, 4);
      check("t1_checksum_hold", csum, 32'hA);

      // T2: zero words -> busy one cycle, done next, no bus cycle
      exp_done(32'h0, 1'b0);
      c0 = cyc_cnt;
      do_start(32'h20, 16'd0);
      @(negedge clk);
      check("t2_cycle1_busy_done", {busy, done}, 2'b10);
      @(negedge clk);
      check("t2_cycle2_busy_done", {busy, done}, 2'b01);
      @(negedge clk);
      check("t2_cycle3_busy_done", {busy, done}, 2'b00);
      check("t2_no_cyc", cyc_cnt - c0, 0);

      // T3: backpressure holds the second word for 10 cycles
      exp_beat(1, 32'h0); exp_beat(2, 32'h4); exp_beat(3, 32'h8); exp_beat(4, 32'hC);
      exp_done(32'hA, 1'b0);
      ready = 1'b0;
      do_start(32'h0, 16'd4);
      wait_valid(50);
      @(posedge clk); #1; ready = 1'b1;
      @(posedge clk); #1; ready = 1'b0;
      wait_valid(50);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("t3_hold_valid_cyc", {rvalid, bus.cyc}, 2'b10);
         check("t3_hold_data", rdata, 32'h2);
         check("t3_hold_adr", radr, 32'h4);
      end
      @(posedge clk); #1; ready = 1'b1;
      wait_done(100);

      // T4: bus error on the third of five words
      err_en = 1'b1; err_adr = 32'h8;
      exp_beat(1, 32'h0); exp_beat(2, 32'h4);
      exp_done(32'h3, 1'b1);
      b0 = beats;
      do_start(32'h0, 16'd5);
      seen = 1'b0;
      for (int k = 0; k < 50 && !seen; k++) begin
         @(negedge clk);
         if (bus.err) seen = 1'b1;
      end
      check("t4_err_seen", seen, 1'b1);
      check("t4_cyc_with_err", bus.cyc, 1'b1);
      @(negedge clk);
      check("t4_cyc_dropped", bus.cyc, 1'b0);
      wait_done(20);
      repeat (3) @(negedge clk);
      check("t4_beats", beats - b0, 2);
      check("t4_err_sticky", err, 1'b1);
      err_en = 1'b0;
      exp_beat(1, 32'h0);
      exp_done(32'h1, 1'b0);
      do_start(32'h0, 16'd1);
      @(negedge clk);
      check("t4_err_cleared", err, 1'b0);
      wait_done(50);

      // T5: no ack -> timeout abort (9 REQ cycles: timer 0..8), then address wrap
      noack = 1'b1;
      exp_done(32'h0, 1'b1);
      c0 = cyc_cnt;
      do_start(32'h40, 16'd1);
      wait_done(100);
      check("t5_req_cycles", cyc_cnt - c0, 9);
      check("t5_err", err, 1'b1);
      noack = 1'b0;
      exp_beat(32'h100, 32'hFFFF_FFFC); exp_beat(1, 32'h0);
      exp_done(32'h101, 1'b0);
      do_start(32'hFFFF_FFFE, 16'd2);
      wait_done(100);

      // T6: async reset in the middle of a request
      do_start(32'h0, 16'd4);
      @(negedge clk);
      check("t6_in_req", bus.cyc, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("t6_async_cyc_stb", {bus.cyc, bus.stb}, 2'b00);
      check("t6_async_busy_valid", {busy, rvalid}, 2'b00);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("t6_idle_after_reset", {busy, bus.cyc}, 2'b00);
      exp_beat(1, 32'h0);
      exp_done(32'h1, 1'b0);
      do_start(32'h0, 16'd1);
      wait_done(50);

      repeat (3) @(negedge clk);
      check("beats_left", beat_q.size(), 0);
      check("dones_left", done_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
